// File: rtl/stream_mux_nto1_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer.
//   mux_mode_e  : selects the sel-driven path (MUX_SEL) or round-robin arbitration (MUX_RR)
//   onehot2idx  : binary index of the set bit of a one-hot vector (0 when all-zero)
package mux_pkg;

  typedef enum logic {
    MUX_SEL = 1'b0,
    MUX_RR  = 1'b1
  } mux_mode_e;

  // Widest one-hot vector onehot2idx accepts; callers zero-extend to this width.
  localparam int unsigned OH_MAX = 64;

  // OR of the indices of all set bits: exact for one-hot input, no priority chain.
  function automatic int unsigned onehot2idx(input logic [OH_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requesting channel at or after ptr_i, wrapping N_CH-1 -> 0.
//   req_i : per-channel request
//   ptr_i : highest-priority channel this cycle
//   gnt_o : one-hot grant (all-zero when nothing requests)
//   idx_o : binary index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [SELW-1:0] idx_o
);

  logic        found;
  int unsigned c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      c = 32'(ptr_i) + i;
      if (c >= N_CH) c = c - N_CH;
      if (!found && req_i[c[SELW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[c[SELW-1:0]]    = 1'b1;
        idx_o                 = c[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-channel, W-bit valid/ready stream multiplexer with a registered output stage.
// Channel choice is either sel-driven (MUX_SEL) or round-robin (MUX_RR); with LOCK_LAST=1
// the grant is held on one channel from its first accepted beat until a beat with i_last=1.
// Ports:
//   i_clk, i_rst : clock (rising edge), asynchronous active-high reset
//   i_valid/o_ready/i_data/i_last : per-channel input streams, channel k at i_data[k*W +: W]
//   i_sel        : channel select, used only in MUX_SEL; codes >= N_CH grant nothing
//   o_valid/i_ready/o_data/o_last : registered output stream
//   o_src        : channel that produced the current output beat
//   o_locked     : a multi-beat packet currently owns the grant
module stream_mux_nto1
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned W         = 32,
  parameter  mux_mode_e   MODE      = MUX_SEL,
  parameter  int unsigned LOCK_LAST = 1,
  localparam int unsigned SELW      = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_valid,
  output logic [N_CH-1:0]   o_ready,
  input  logic [N_CH*W-1:0] i_data,
  input  logic [N_CH-1:0]   i_last,
  input  logic [SELW-1:0]   i_sel,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W-1:0]      o_data,
  output logic              o_last,
  output logic [SELW-1:0]   o_src,
  output logic              o_locked
);

  logic            valid_q,   valid_d;
  logic [W-1:0]    data_q,    data_d;
  logic            last_q,    last_d;
  logic [SELW-1:0] src_q,     src_d;
  logic            locked_q,  locked_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  logic            adv;
  logic [N_CH-1:0] sel_gnt, lock_gnt, rr_gnt, gnt, xfer;
  logic [SELW-1:0] rr_idx, xfer_idx;
  logic            xfer_any, xfer_last, pkt_end;
  logic [W-1:0]    xfer_data;

  // Decode i_sel and the lock channel by comparison so codes >= N_CH match nothing.
  always_comb begin
    sel_gnt  = '0;
    lock_gnt = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sel_gnt[k]  = (i_sel == SELW'(k));
      lock_gnt[k] = (lock_ch_q == SELW'(k));
    end
  end

  assign gnt = locked_q ? lock_gnt : ((MODE == MUX_RR) ? rr_gnt : sel_gnt);

  // Nothing is accepted while reset is asserted: the output register cannot capture,
  // so granting ready would silently lose the upstream beat.
  assign adv     = (!valid_q || i_ready) && !i_rst;
  assign o_ready = gnt & {N_CH{adv}};
  assign xfer    = i_valid & o_ready;

  assign xfer_any  = |xfer;
  assign xfer_last = |(xfer & i_last);
  assign pkt_end   = xfer_last || (LOCK_LAST == 0);

  // AND-OR select over the one-hot grant.
  always_comb begin
    xfer_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      xfer_data |= i_data[k*W +: W] & {W{gnt[k]}};
    end
  end

  always_comb begin
    if (locked_q)             xfer_idx = lock_ch_q;
    else if (MODE == MUX_RR)  xfer_idx = rr_idx;
    else                      xfer_idx = SELW'(onehot2idx(OH_MAX'(gnt)));
  end

  generate
    if (MODE == MUX_RR) begin : g_rr
      logic [SELW-1:0] ptr_q, ptr_d;

      rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i (i_valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
      );

      // Pointer moves past a channel only once its packet has finished.
      always_comb begin
        ptr_d = ptr_q;
        if (xfer_any && pkt_end) begin
          ptr_d = (32'(xfer_idx) == N_CH - 1) ? '0 : SELW'(xfer_idx + 1'b1);
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
      end
    end else begin : g_sel
      assign rr_gnt = '0;
      assign rr_idx = '0;
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    src_d     = src_q;
    locked_d  = locked_q;
    lock_ch_d = lock_ch_q;
    if (adv) begin
      valid_d = xfer_any;
      if (xfer_any) begin
        data_d = xfer_data;
        last_d = xfer_last;
        src_d  = xfer_idx;
      end
    end
    if (xfer_any && (LOCK_LAST != 0)) begin
      locked_d  = !xfer_last;
      lock_ch_d = xfer_idx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      src_q     <= '0;
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      src_q     <= src_d;
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_last   = last_q;
  assign o_src    = src_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
module tb_stream_mux_nto1;
  import mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: MUX_SEL instance, index 1: MUX_RR instance
  logic [N-1:0]   vld[2], rdy_o[2], lst[2];
  logic [N*W-1:0] dat[2];
  logic [SW-1:0]  sel[2];
  logic           ir[2], ov[2], ol[2], olk[2];
  logic [W-1:0]   od[2];
  logic [SW-1:0]  osrc[2];

  stream_mux_nto1 #(.N_CH(N), .W(W), .MODE(MUX_SEL), .LOCK_LAST(1)) u_sel (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(rdy_o[0]), .i_data(dat[0]),
    .i_last(lst[0]), .i_sel(sel[0]), .o_valid(ov[0]), .i_ready(ir[0]), .o_data(od[0]),
    .o_last(ol[0]), .o_src(osrc[0]), .o_locked(olk[0]));

  stream_mux_nto1 #(.N_CH(N), .W(W), .MODE(MUX_RR), .LOCK_LAST(1)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(rdy_o[1]), .i_data(dat[1]),
    .i_last(lst[1]), .i_sel(sel[1]), .o_valid(ov[1]), .i_ready(ir[1]), .o_data(od[1]),
    .o_last(ol[1]), .o_src(osrc[1]), .o_locked(olk[1]));

  typedef struct {
    logic [W-1:0]  d;
    logic          l;
    logic [SW-1:0] s;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  // Reference model state: output slot occupancy, packet lock, RR pointer.
  bit           m_full[2];
  bit           m_lock[2];
  int           m_lch[2];
  int           m_ptr[2];
  logic [N-1:0] e_rdy[2];
  bit           e_val[2], e_lock[2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_full[d] = 0; m_lock[d] = 0; m_lch[d] = 0; m_ptr[d] = 0;
    e_rdy[d] = '0; e_val[d] = 0; e_lock[d] = 0;
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  // Applies this cycle's inputs to the model: works out which channel the rules grant,
  // whether a beat is accepted, and queues the beat the consumer should later see.
  task automatic model(input int d);
    bit    adv;
    int    g;
    int    c;
    beat_t b;
    if (rst) begin
      model_reset(d);
      return;
    end
    adv = !m_full[d] || ir[d];
    g   = -1;
    if (m_lock[d]) g = m_lch[d];
    else if (d == 0) begin
      if (int'(sel[0]) < N) g = int'(sel[0]);
    end else begin
      for (int j = 0; j < N; j++) begin
        c = (m_ptr[1] + j) % N;
        if (g < 0 && vld[1][c]) g = c;
      end
    end
    e_rdy[d]  = '0;
    if (adv && g >= 0) e_rdy[d][g] = 1'b1;
    e_val[d]  = m_full[d];
    e_lock[d] = m_lock[d];
    if (adv) begin
      if (g >= 0 && vld[d][g]) begin
        b.d = dat[d][g*W +: W];
        b.l = lst[d][g];
        b.s = SW'(g);
        if (d == 0) q0.push_back(b); else q1.push_back(b);
        m_full[d] = 1;
        if (lst[d][g]) begin
          m_lock[d] = 0;
          m_ptr[d]  = (g + 1) % N;
        end else begin
          m_lock[d] = 1;
          m_lch[d]  = g;
        end
      end else begin
        m_full[d] = 0;
      end
    end
  endtask

  // Inputs are set #1 after a rising edge; apply() feeds them to the model and
  // returns #1 after the edge that consumes them.
  task automatic apply();
    model(0);
    model(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; lst[d] = '1; ir[d] = 1'b1; sel[d] = '0; dat[d] = '0;
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    apply();
    rst = 1'b0;
  endtask

  // Monitor: compares handshake signals against the model every cycle and pops the
  // scoreboard whenever an output beat is taken by the consumer.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("o_ready[%0d]", d), 64'(rdy_o[d]), 64'(e_rdy[d]));
        chk($sformatf("o_valid[%0d]", d), 64'(ov[d]), 64'(e_val[d]));
        chk($sformatf("o_locked[%0d]", d), 64'(olk[d]), 64'(e_lock[d]));
        if (ov[d] && ir[d]) begin
          checks++;
          if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            errors++;
            $display("FAIL beat[%0d]: got unexpected beat data=%0h expected none", d, od[d]);
          end else begin
            b = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (od[d] !== b.d || ol[d] !== b.l || osrc[d] !== b.s) begin
              errors++;
              $display("FAIL beat[%0d]: got data=%0h last=%0b src=%0d expected data=%0h last=%0b src=%0d",
                       d, od[d], ol[d], osrc[d], b.d, b.l, b.s);
            end
          end
        end
      end
    end
  end

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    for (int d = 0; d < 2; d++) model_reset(d);

    // Reset with every channel valid: nothing may be accepted.
    idle_all();
    rst = 1'b1;
    vld[0] = '1; vld[1] = '1;
    repeat (3) @(negedge clk);
    chk("rst o_ready sel", 64'(rdy_o[0]), 64'(0));
    chk("rst o_ready rr", 64'(rdy_o[1]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();
    for (int d = 0; d < 2; d++) begin
      chk("rst o_valid", 64'(ov[d]), 64'(0));
      chk("rst o_data", 64'(od[d]), 64'(0));
      chk("rst o_src", 64'(osrc[d]), 64'(0));
      chk("rst o_locked", 64'(olk[d]), 64'(0));
    end
    apply();

    // MUX_SEL directed
    sel[0] = 2'd2; vld[0] = 4'b0100; dat[0][2*W +: W] = 32'hDEADBEEF;
    apply();
    chk("sel o_valid", 64'(ov[0]), 64'(1));
    chk("sel o_data", 64'(od[0]), 64'hDEADBEEF);
    chk("sel o_src", 64'(osrc[0]), 64'(2));
    sel[0] = 2'd3; vld[0] = 4'b0100;
    apply();
    chk("sel novalid o_valid", 64'(ov[0]), 64'(0));
    vld[0] = '0;

    // MUX_RR rotation
    rst_pulse();
    vld[1] = '1; lst[1] = '1;
    for (int i = 0; i < 5; i++) begin
      dat[1] = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
      apply();
      chk("rr rotate o_src", 64'(osrc[1]), 64'(seq[i]));
    end
    vld[1] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      apply();
      chk("rr single o_src", 64'(osrc[1]), 64'(2));
    end

    // Backpressure
    vld[1] = 4'b0001; dat[1][0 +: W] = 32'h11;
    apply();
    chk("bp first o_data", 64'(od[1]), 64'h11);
    ir[1] = 1'b0; vld[1] = 4'b0010; dat[1][W +: W] = 32'h22;
    for (int i = 0; i < 3; i++) begin
      apply();
      chk("bp hold o_data", 64'(od[1]), 64'h11);
      chk("bp hold o_ready", 64'(rdy_o[1]), 64'(0));
    end
    ir[1] = 1'b1;
    apply();
    chk("bp release o_data", 64'(od[1]), 64'h22);
    vld[1] = '0;
    apply();

    // Lock: ch1 3-beat packet with ch0 valid throughout
    rst_pulse();
    vld[1] = 4'b0001; lst[1] = 4'b0001; dat[1][0 +: W] = 32'hA0;
    apply();
    vld[1] = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      lst[1] = (i == 2) ? 4'b0011 : 4'b0001;
      dat[1][W +: W] = 32'hB0 + 32'(i);
      apply();
      chk("lock o_src", 64'(osrc[1]), 64'(1));
      chk("lock o_locked", 64'(olk[1]), 64'((i < 2) ? 1 : 0));
    end
    vld[1] = 4'b0001;
    apply();
    chk("lock after o_src", 64'(osrc[1]), 64'(0));

    // Reset mid-packet
    rst_pulse();
    vld[1] = 4'b0001; lst[1] = 4'b0001;
    apply();
    vld[1] = 4'b0011; lst[1] = 4'b0001;
    apply();
    apply();
    chk("midpkt locked", 64'(olk[1]), 64'(1));
    rst = 1'b1;
    #1;
    chk("midpkt rst o_locked", 64'(olk[1]), 64'(0));
    chk("midpkt rst o_valid", 64'(ov[1]), 64'(0));
    apply();
    rst = 1'b0;
    vld[1] = 4'b0011; lst[1] = 4'b0011;
    apply();
    chk("midpkt regrant o_src", 64'(osrc[1]), 64'(0));

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        vld[d] = N'($urandom);
        lst[d] = N'($urandom);
        sel[d] = SW'($urandom);
        ir[d]  = ($urandom_range(0, 9) < 7);
        for (int k = 0; k < N; k++) dat[d][k*W +: W] = $urandom;
      end
      apply();
    end

    idle_all();
    repeat (4) apply();
    chk("drain sel", 64'(q0.size()), 64'(0));
    chk("drain rr", 64'(q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
